// File: rtl/pc_unit.sv
// Program-counter unit: sequential advance plus jr > jmp > branch redirects.
// Define PC_UNIT_RAS_EN to add a circular return-address stack for call/ret.
module pc_unit #(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter int unsigned       RAS_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                fetch_ready,
   input  logic                br_taken,
   input  logic signed [15:0]  br_off,
   input  logic                jmp,
   input  logic [25:0]         jmp_target,
   input  logic                jr,
   input  logic [ADDR_W-1:0]   jr_addr,
   input  logic                call,
   input  logic                ret,
   output logic [ADDR_W-1:0]   pc,
   output logic                pc_valid,
   output logic                misalign_err
);

   logic [ADDR_W-1:0] seq_pc;
   logic [ADDR_W-1:0] next_pc;
   logic              next_misalign;

   function automatic logic [ADDR_W-1:0] br_dest(input logic [ADDR_W-1:0] seq,
                                                 input logic signed [15:0] off);
      logic signed [ADDR_W-1:0] disp;
      disp = {{(ADDR_W-16){off[15]}}, off};
      return seq + $unsigned(disp <<< 2);
   endfunction

   // Upper bits come from the 256 MB region of the following instruction.
   function automatic logic [ADDR_W-1:0] jmp_dest(input logic [ADDR_W-1:0] seq,
                                                  input logic [25:0] idx);
      logic [ADDR_W-1:0] region;
      region = {ADDR_W{1'b1}} << 28;
      return (seq & region) | ADDR_W'({idx, 2'b00});
   endfunction

   assign seq_pc = pc + ADDR_W'(4);

`ifdef PC_UNIT_RAS_EN
   localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

   logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0]  ras_top;
   logic [CNT_W-1:0]  ras_count;
   logic              ras_push;
   logic              ras_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RAS_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
      return (p == '0) ? PTR_W'(RAS_DEPTH - 1) : p - PTR_W'(1);
   endfunction

   // ras_top always names the newest entry; a push onto a full stack lands on the oldest.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ras_top   <= '0;
         ras_count <= '0;
      end else if (ras_push) begin
         ras_top <= ptr_inc(ras_top);
         if (ras_count != CNT_W'(RAS_DEPTH))
            ras_count <= ras_count + CNT_W'(1);
      end else if (ras_pop) begin
         ras_top   <= ptr_dec(ras_top);
         ras_count <= ras_count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst && ras_push)
         ras_mem[ptr_inc(ras_top)] <= seq_pc;
   end
`else
   logic unused_ras;
   assign unused_ras = call ^ ret;
`endif

   always_comb begin
      next_pc       = pc;
      next_misalign = 1'b0;
`ifdef PC_UNIT_RAS_EN
      ras_push      = 1'b0;
      ras_pop       = 1'b0;
`endif
      if (pc_valid) begin
         if (jr) begin
`ifdef PC_UNIT_RAS_EN
            if (ret && (ras_count != '0)) begin
               ras_pop = 1'b1;
               next_pc = ras_mem[ras_top];
            end else
`endif
            begin
               next_pc       = {jr_addr[ADDR_W-1:2], 2'b00};
               next_misalign = |jr_addr[1:0];
            end
         end else if (jmp) begin
            next_pc = jmp_dest(seq_pc, jmp_target);
`ifdef PC_UNIT_RAS_EN
            ras_push = call;
`endif
         end else if (br_taken) begin
            next_pc = br_dest(seq_pc, br_off);
         end else if (fetch_ready) begin
            next_pc = seq_pc;
         end
      end
   end

   // Fetch-address register stage
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc           <= RESET_VEC;
         pc_valid     <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         pc           <= next_pc;
         pc_valid     <= 1'b1;
         misalign_err <= next_misalign;
      end
   end

endmodule
